div_sched: RTL and testbench

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched.sv | 130 +++++++++++++
 tb/tb_div_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// Programmable clock divider with 50% duty for odd and even ratios.
// Ratio changes are queued and take effect only on a divided-period boundary.
module div_sched #(
  parameter int W     = 8,
  parameter int DEF_N = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_n,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic [W-1:0] cur_n,
  output logic         clk_out,
  output logic         locked
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t       state_r;
  logic [W-1:0] cnt_r;
  logic [W-1:0] cur_n_r;
  logic [W-1:0] pend_n_r;
  logic         q_pos_r;
  logic         q_neg_r;
  logic         cfg_err_r;
  logic         cfg_ready_r;
  logic         locked_r;

  logic         accept_s;
  logic         legal_s;
  logic         last_s;
  logic [W-1:0] half_s;

  assign accept_s = cfg_valid & cfg_ready_r;
  assign legal_s  = (cfg_n >= W'(2));
  assign last_s   = (cnt_r == (cur_n_r - W'(1)));
  // ceil(cur_n/2): number of counts for which q_pos is high
  assign half_s   = {1'b0, cur_n_r[W-1:1]} + W'(cur_n_r[0]);

  // Controller FSM: counter, ratio bookkeeping and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= W'(0);
      cur_n_r     <= W'(DEF_N);
      pend_n_r    <= W'(DEF_N);
      q_pos_r     <= 1'b0;
      cfg_err_r   <= 1'b0;
      cfg_ready_r <= 1'b1;
      locked_r    <= 1'b0;
    end else begin
      cfg_err_r <= accept_s & ~legal_s;
      case (state_r)
        ST_IDLE: begin
          cnt_r   <= W'(0);
          q_pos_r <= 1'b0;
          if (accept_s && legal_s) begin
            cur_n_r <= cfg_n;
          end
          if (en) begin
            state_r     <= ST_RUN;
            locked_r    <= 1'b1;
            cfg_ready_r <= 1'b1;
          end
        end
        ST_RUN, ST_PEND: begin
          // q_pos lags cnt by one edge, so the first rise follows the start edge
          q_pos_r <= (cnt_r < half_s);
          if (last_s) begin
            cnt_r <= W'(0);
            if (state_r == ST_PEND) begin
              cur_n_r <= pend_n_r;
            end
            if (!en) begin
              state_r     <= ST_IDLE;
              locked_r    <= 1'b0;
              cfg_ready_r <= 1'b1;
              if (state_r == ST_RUN && accept_s && legal_s) begin
                cur_n_r <= cfg_n;
              end
            end else if (state_r == ST_RUN && accept_s && legal_s) begin
              pend_n_r    <= cfg_n;
              state_r     <= ST_PEND;
              cfg_ready_r <= 1'b0;
            end else begin
              state_r     <= ST_RUN;
              cfg_ready_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + W'(1);
            if (state_r == ST_RUN && accept_s && legal_s) begin
              pend_n_r    <= cfg_n;
              state_r     <= ST_PEND;
              cfg_ready_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= W'(0);
          q_pos_r     <= 1'b0;
          cfg_ready_r <= 1'b1;
          locked_r    <= 1'b0;
        end
      endcase
    end
  end

  // Half-cycle delayed copy of q_pos used to stretch odd ratios to 50% duty
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q_neg_r <= 1'b0;
    end else begin
      q_neg_r <= q_pos_r;
    end
  end

  assign clk_out   = cur_n_r[0] ? (q_pos_r & q_neg_r) : q_pos_r;
  assign cfg_ready = cfg_ready_r;
  assign cfg_err   = cfg_err_r;
  assign cur_n     = cur_n_r;
  assign locked    = locked_r;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed scenarios plus random traffic,
// compared against a half-cycle-resolution behavioural model.
module tb_div_sched;

  localparam int W     = 8;
  localparam int DEF_N = 7;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PEND = 2;

  logic         clk;
  logic         rst;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_n;
  logic         cfg_ready;
  logic         cfg_err;
  logic [W-1:0] cur_n;
  logic         clk_out;
  logic         locked;

  int n_total;
  int n_pass;

  // Model: mode, count inside the divided period, ratio in effect, queued ratio
  int m_mode;
  int m_c;
  int m_cur;
  int m_pend;
  int m_err;

  div_sched #(.W(W), .DEF_N(DEF_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_n     (cfg_n),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cur_n     (cur_n),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total = n_total + 1;
    if (got == exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output is high for n half-cycles, ending 2*ceil(n/2)+1 half-cycles into the period.
  function automatic int exp_clk(input int mode, input int c, input int n, input int hh);
    int hi;
    int lo;
    if (mode == M_IDLE) return 0;
    hi = 2 * ((n + 1) / 2) + 1;
    lo = hi - n + 1;
    return ((2 * c + hh) >= lo && (2 * c + hh) <= hi) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_c    = 0;
    m_cur  = DEF_N;
    m_pend = DEF_N;
    m_err  = 0;
  endtask

  task automatic model_step(input logic e, input logic v, input int n);
    bit acc;
    bit take;
    acc   = v && (m_mode != M_PEND);
    take  = acc && (n >= 2);
    m_err = (acc && !(n >= 2)) ? 1 : 0;
    if (m_mode == M_IDLE) begin
      if (take) m_cur = n;
      if (e) m_mode = M_RUN;
      m_c = 0;
    end else if (m_c == m_cur - 1) begin
      if (m_mode == M_PEND) m_cur = m_pend;
      m_c = 0;
      if (!e) begin
        if (m_mode == M_RUN && take) m_cur = n;
        m_mode = M_IDLE;
      end else if (m_mode == M_RUN && take) begin
        m_pend = n;
        m_mode = M_PEND;
      end else begin
        m_mode = M_RUN;
      end
    end else begin
      m_c = m_c + 1;
      if (m_mode == M_RUN && take) begin
        m_pend = n;
        m_mode = M_PEND;
      end
    end
  endtask

  // One reference-clock cycle: drive, step model at posedge, check both half-cycles
  task automatic tick(input logic e, input logic v, input int n);
    en        = e;
    cfg_valid = v;
    cfg_n     = W'(n);
    @(posedge clk);
    model_step(e, v, n);
    #1;
    check_val("clk_out_hi_phase", int'(clk_out), exp_clk(m_mode, m_c, m_cur, 0));
    check_val("cfg_ready", int'(cfg_ready), (m_mode != M_PEND) ? 1 : 0);
    check_val("cfg_err", int'(cfg_err), m_err);
    check_val("locked", int'(locked), (m_mode != M_IDLE) ? 1 : 0);
    check_val("cur_n", int'(cur_n), m_cur);
    @(negedge clk);
    #1;
    check_val("clk_out_lo_phase", int'(clk_out), exp_clk(m_mode, m_c, m_cur, 1));
  endtask

  task automatic run_cycles(input int k, input logic e);
    for (int i = 0; i < k; i++) tick(e, 1'b0, 0);
  endtask

  task automatic wait_count(input int target, input logic e);
    for (int i = 0; i < 300 && m_c != target; i++) tick(e, 1'b0, 0);
  endtask

  // Asynchronous reset applied between edges; outputs must drop immediately
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check_val("rst_clk_out", int'(clk_out), 0);
    check_val("rst_locked", int'(locked), 0);
    check_val("rst_cfg_ready", int'(cfg_ready), 1);
    check_val("rst_cur_n", int'(cur_n), DEF_N);
    check_val("rst_cfg_err", int'(cfg_err), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit run_flag;
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_n     = W'(0);
    model_reset();
    @(negedge clk);
    apply_reset();

    // Stays idle after reset until en is seen high
    run_cycles(3, 1'b0);
    // Default ratio 7: 3.5-cycle high time
    run_cycles(24, 1'b1);
    // Illegal ratios rejected while running
    tick(1'b1, 1'b1, 1);
    tick(1'b1, 1'b1, 0);
    run_cycles(10, 1'b1);
    // Ratio 5 offered at cnt=2, applied after the current period of 7
    wait_count(2, 1'b1);
    tick(1'b1, 1'b1, 5);
    run_cycles(20, 1'b1);
    // Back to 7, then stop requested at cnt=1
    tick(1'b1, 1'b1, 7);
    run_cycles(12, 1'b1);
    wait_count(1, 1'b1);
    run_cycles(12, 1'b0);
    // Idle reconfiguration to 4, then run
    tick(1'b0, 1'b1, 4);
    run_cycles(14, 1'b1);
    // Cancelled stop: en drops briefly mid-period
    wait_count(1, 1'b1);
    run_cycles(1, 1'b0);
    run_cycles(10, 1'b1);
    // Queue a change to 5 from ratio 7, then reset while pending and clk_out high
    tick(1'b1, 1'b1, 7);
    run_cycles(8, 1'b1);
    wait_count(2, 1'b1);
    tick(1'b1, 1'b1, 5);
    wait_count(4, 1'b1);
    check_val("pre_rst_clk_out", int'(clk_out), 1);
    apply_reset();
    run_cycles(2, 1'b0);
    run_cycles(20, 1'b1);

    // Random traffic
    run_flag = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      int n;
      bit v;
      if ($urandom_range(0, 39) == 0) run_flag = ~run_flag;
      v = ($urandom_range(0, 7) == 0);
      n = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12);
      tick(run_flag, v, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
